// File: rtl/fifo_strm_chk.sv
// -----------------------------------------------------------------------------
// fifo_strm_chk
// Receive-side data-stream checker for the FT600 FIFO master. Snoops every word
// the master reads from the FT600 (qualified by the RAM write strobe) and checks
// that the host sends a 32-bit incrementing pattern. The first word after enable
// (or after a clear) seeds the expected value; later words are compared byte by
// byte where the byte enable is set.
//
// Ports
//   fifoClk    in   1      FT600 FIFO clock, only clock
//   fifoRstn   in   1      asynchronous active-low reset
//   chk_en     in   1      1 = checking enabled, 0 = idle with counters held
//   chk_clr    in   1      synchronous clear of counters, flags and captures
//   rx_vld     in   1      received word valid (RAM write strobe)
//   rx_data    in   DW     received word
//   rx_be      in   BEW    received byte enables, 1 = byte valid
//   word_cnt   out  CNT_W  words accepted while checking, seed included (saturating)
//   err_cnt    out  CNT_W  words with at least one bad enabled byte (saturating)
//   err_flag   out  1      sticky error since last clear/reset
//   synced     out  1      seed taken, comparing against exp_data
//   exp_data   out  DW     next expected word
//   ferr_data  out  DW     received word of the first error
//   ferr_exp   out  DW     expected word at the first error
// -----------------------------------------------------------------------------
module fifo_strm_chk #(
    parameter int DW    = 32,
    parameter int BEW   = DW / 8,
    parameter int CNT_W = 32
) (
    input  logic             fifoClk,
    input  logic             fifoRstn,
    input  logic             chk_en,
    input  logic             chk_clr,
    input  logic             rx_vld,
    input  logic [DW-1:0]    rx_data,
    input  logic [BEW-1:0]   rx_be,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic             synced,
    output logic [DW-1:0]    exp_data,
    output logic [DW-1:0]    ferr_data,
    output logic [DW-1:0]    ferr_exp
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [DW-1:0]    DATA_ONE = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Expand one enable bit per byte into a full-width bit mask.
    function automatic logic [DW-1:0] be_to_mask(input logic [BEW-1:0] be);
        logic [DW-1:0] mask;
        mask = {DW{1'b0}};
        for (int i = 0; i < BEW; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

    // Any enabled byte of the received word differs from the expected word.
    function automatic logic byte_mismatch(input logic [DW-1:0]  data,
                                           input logic [DW-1:0]  expv,
                                           input logic [BEW-1:0] be);
        return |((data ^ expv) & be_to_mask(be));
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    state_t        state_r;
    logic          mismatch_s;
    logic [DW-1:0] seed_next_s;

    // Compare result for the current word and the expected value after a seed
    // (disabled bytes of the seed count as zero).
    always_comb begin
        mismatch_s  = byte_mismatch(rx_data, exp_data, rx_be);
        seed_next_s = (rx_data & be_to_mask(rx_be)) + DATA_ONE;
    end

    // Checker state machine with all outputs registered; clear beats enable,
    // and enable low beats any received word.
    always_ff @(posedge fifoClk or negedge fifoRstn) begin
        if (!fifoRstn) begin
            state_r   <= ST_IDLE;
            word_cnt  <= {CNT_W{1'b0}};
            err_cnt   <= {CNT_W{1'b0}};
            err_flag  <= 1'b0;
            synced    <= 1'b0;
            exp_data  <= {DW{1'b0}};
            ferr_data <= {DW{1'b0}};
            ferr_exp  <= {DW{1'b0}};
        end else if (chk_clr) begin
            // exp_data is deliberately left alone: it is reloaded by the next seed.
            word_cnt  <= {CNT_W{1'b0}};
            err_cnt   <= {CNT_W{1'b0}};
            err_flag  <= 1'b0;
            synced    <= 1'b0;
            ferr_data <= {DW{1'b0}};
            ferr_exp  <= {DW{1'b0}};
            state_r   <= chk_en ? ST_SEED : ST_IDLE;
        end else if (!chk_en) begin
            state_r <= ST_IDLE;
            synced  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A word arriving in the enable cycle is not used as seed.
                    state_r <= ST_SEED;
                end
                ST_SEED: begin
                    if (rx_vld) begin
                        exp_data <= seed_next_s;
                        word_cnt <= sat_inc(word_cnt);
                        synced   <= 1'b1;
                        state_r  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (rx_vld) begin
                        // No resync on error: the expected sequence keeps running.
                        exp_data <= exp_data + DATA_ONE;
                        word_cnt <= sat_inc(word_cnt);
                        if (mismatch_s) begin
                            err_cnt  <= sat_inc(err_cnt);
                            err_flag <= 1'b1;
                            if (!err_flag) begin
                                ferr_data <= rx_data;
                                ferr_exp  <= exp_data;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    synced  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_strm_chk.sv
// -----------------------------------------------------------------------------
// tb_fifo_strm_chk
// Self-checking bench for fifo_strm_chk. Counters are built 9 bits wide so that
// saturation can be reached in a short run. A behavioural model tracks whether
// the checker is enabled, whether it holds a seed, and the expected stream value;
// directed scenarios check against literal values, the random scenario against
// the model.
// -----------------------------------------------------------------------------
module tb_fifo_strm_chk;

    localparam int DW    = 32;
    localparam int BEW   = 4;
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] CMAX = 9'd511;

    logic             fifoClk;
    logic             fifoRstn;
    logic             chk_en;
    logic             chk_clr;
    logic             rx_vld;
    logic [DW-1:0]    rx_data;
    logic [BEW-1:0]   rx_be;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_flag;
    logic             synced;
    logic [DW-1:0]    exp_data;
    logic [DW-1:0]    ferr_data;
    logic [DW-1:0]    ferr_exp;

    int n_tests;
    int n_fail;

    // Reference model state
    logic             m_active;   // enabled for at least one cycle (seed window open)
    logic             m_synced;
    logic [DW-1:0]    m_exp;
    logic [CNT_W-1:0] m_words;
    logic [CNT_W-1:0] m_errs;
    logic             m_flag;
    logic [DW-1:0]    m_fdata;
    logic [DW-1:0]    m_fexp;

    fifo_strm_chk #(.DW(DW), .BEW(BEW), .CNT_W(CNT_W)) dut (
        .fifoClk   (fifoClk),
        .fifoRstn  (fifoRstn),
        .chk_en    (chk_en),
        .chk_clr   (chk_clr),
        .rx_vld    (rx_vld),
        .rx_data   (rx_data),
        .rx_be     (rx_be),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .synced    (synced),
        .exp_data  (exp_data),
        .ferr_data (ferr_data),
        .ferr_exp  (ferr_exp)
    );

    initial begin
        fifoClk = 1'b0;
        forever #5 fifoClk = ~fifoClk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_active = 1'b0;
        m_synced = 1'b0;
        m_exp    = '0;
        m_words  = '0;
        m_errs   = '0;
        m_flag   = 1'b0;
        m_fdata  = '0;
        m_fexp   = '0;
    endtask

    // One clocked step of the checker rules as seen from outside.
    task automatic model_step(input logic en, input logic clr, input logic vld,
                              input logic [DW-1:0] d, input logic [BEW-1:0] b);
        logic           bad;
        logic [DW-1:0]  masked;
        if (clr) begin
            m_words = '0; m_errs = '0; m_flag = 1'b0;
            m_fdata = '0; m_fexp = '0;
            m_synced = 1'b0;
            m_active = en;
        end else if (!en) begin
            m_active = 1'b0;
            m_synced = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
        end else if (vld) begin
            if (m_words != CMAX) m_words = m_words + 9'd1;
            if (!m_synced) begin
                masked = '0;
                for (int i = 0; i < BEW; i++)
                    if (b[i]) masked[8*i +: 8] = d[8*i +: 8];
                m_exp    = masked + 32'd1;
                m_synced = 1'b1;
            end else begin
                bad = 1'b0;
                for (int i = 0; i < BEW; i++)
                    if (b[i] && (d[8*i +: 8] != m_exp[8*i +: 8])) bad = 1'b1;
                if (bad) begin
                    if (m_errs != CMAX) m_errs = m_errs + 9'd1;
                    if (!m_flag) begin
                        m_fdata = d;
                        m_fexp  = m_exp;
                    end
                    m_flag = 1'b1;
                end
                m_exp = m_exp + 32'd1;
            end
        end
    endtask

    // Drive one cycle of inputs from a falling edge; return on the next falling edge.
    task automatic cycle(input logic en, input logic clr, input logic vld,
                         input logic [DW-1:0] d, input logic [BEW-1:0] b);
        chk_en  = en;
        chk_clr = clr;
        rx_vld  = vld;
        rx_data = d;
        rx_be   = b;
        @(posedge fifoClk);
        model_step(en, clr, vld, d, b);
        @(negedge fifoClk);
    endtask

    task automatic test_reset();
        fifoRstn = 1'b0;
        chk_en = 1'b1; chk_clr = 1'b0; rx_vld = 1'b1;
        rx_data = 32'h1234_5678; rx_be = 4'hF;
        model_reset();
        repeat (3) @(negedge fifoClk);
        n_tests++;
        if ({word_cnt, err_cnt, err_flag, synced, exp_data, ferr_data, ferr_exp} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: wc=%0d ec=%0d flag=%b sync=%b exp=%h fd=%h fe=%h, all zero required",
                     word_cnt, err_cnt, err_flag, synced, exp_data, ferr_data, ferr_exp);
        end
        fifoRstn = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic test_incrementing();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);  // enable: idle -> seed window
        for (int i = 0; i < 256; i++)
            cycle(1'b1, 1'b0, 1'b1, 32'h10 + i, 4'hF);
        n_tests++;
        if (word_cnt !== 9'd256) begin
            n_fail++; $display("FAIL inc_word_cnt: got %0d want 256", word_cnt);
        end
        n_tests++;
        if (err_cnt !== 9'd0 || err_flag !== 1'b0) begin
            n_fail++; $display("FAIL inc_err: got cnt=%0d flag=%b want 0/0", err_cnt, err_flag);
        end
        n_tests++;
        if (exp_data !== 32'h110 || synced !== 1'b1) begin
            n_fail++; $display("FAIL inc_exp: got %h sync=%b want 00000110 sync=1", exp_data, synced);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] seq [4];
        seq[0] = 32'hFFFF_FFFE; seq[1] = 32'hFFFF_FFFF; seq[2] = 32'h0; seq[3] = 32'h1;
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        foreach (seq[i]) cycle(1'b1, 1'b0, 1'b1, seq[i], 4'hF);
        n_tests++;
        if (err_cnt !== 9'd0 || word_cnt !== 9'd4) begin
            n_fail++; $display("FAIL wrap_counts: got wc=%0d ec=%0d want 4/0", word_cnt, err_cnt);
        end
        n_tests++;
        if (exp_data !== 32'h2) begin
            n_fail++; $display("FAIL wrap_exp: got %h want 00000002", exp_data);
        end
    endtask

    task automatic test_first_error();
        logic [DW-1:0] seq [6];
        seq[0] = 32'h0; seq[1] = 32'h1; seq[2] = 32'h2;
        seq[3] = 32'h55; seq[4] = 32'h4; seq[5] = 32'h77;
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        foreach (seq[i]) cycle(1'b1, 1'b0, 1'b1, seq[i], 4'hF);
        n_tests++;
        if (err_cnt !== 9'd2 || err_flag !== 1'b1) begin
            n_fail++; $display("FAIL ferr_cnt: got ec=%0d flag=%b want 2/1", err_cnt, err_flag);
        end
        n_tests++;
        if (ferr_data !== 32'h55 || ferr_exp !== 32'h3) begin
            n_fail++; $display("FAIL ferr_capture: got data=%h exp=%h want 00000055/00000003",
                               ferr_data, ferr_exp);
        end
        n_tests++;
        if (exp_data !== 32'h6) begin
            n_fail++; $display("FAIL ferr_exp_data: got %h want 00000006", exp_data);
        end
    endtask

    task automatic test_byte_enable();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'hDEAD_BE00, 4'b0001);  // masked seed = 0
        n_tests++;
        if (exp_data !== 32'h1) begin
            n_fail++; $display("FAIL be_seed: got %h want 00000001", exp_data);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'hAA00_0001, 4'b0001);
        n_tests++;
        if (err_cnt !== 9'd0) begin
            n_fail++; $display("FAIL be_masked_ok: got ec=%0d want 0", err_cnt);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'hAA00_0002, 4'b1001);
        n_tests++;
        if (err_cnt !== 9'd1 || ferr_exp !== 32'h2) begin
            n_fail++; $display("FAIL be_upper_err: got ec=%0d fexp=%h want 1/00000002", err_cnt, ferr_exp);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000);
        n_tests++;
        if (err_cnt !== 9'd1 || word_cnt !== 9'd4 || exp_data !== 32'h4) begin
            n_fail++; $display("FAIL be_zero: got ec=%0d wc=%0d exp=%h want 1/4/00000004",
                               err_cnt, word_cnt, exp_data);
        end
    endtask

    task automatic test_clear_collision();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h100, 4'hF);
        cycle(1'b1, 1'b0, 1'b1, 32'h999, 4'hF);
        cycle(1'b1, 1'b0, 1'b1, 32'h102, 4'hF);
        cycle(1'b1, 1'b1, 1'b1, 32'h103, 4'hF);
        n_tests++;
        if ({word_cnt, err_cnt, err_flag, synced, ferr_data, ferr_exp} !== '0) begin
            n_fail++; $display("FAIL clr_outputs: wc=%0d ec=%0d flag=%b sync=%b fd=%h fe=%h, zero required",
                               word_cnt, err_cnt, err_flag, synced, ferr_data, ferr_exp);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'h1234, 4'hF);
        n_tests++;
        if (exp_data !== 32'h1235 || word_cnt !== 9'd1 || synced !== 1'b1 || err_cnt !== 9'd0) begin
            n_fail++; $display("FAIL clr_reseed: exp=%h wc=%0d sync=%b ec=%0d want 00001235/1/1/0",
                               exp_data, word_cnt, synced, err_cnt);
        end
    endtask

    task automatic test_disable_hold();
        cycle(1'b1, 1'b0, 1'b1, 32'h1235, 4'hF);
        cycle(1'b1, 1'b0, 1'b1, 32'h0, 4'hF);      // error
        cycle(1'b0, 1'b0, 1'b1, 32'h5, 4'hF);      // disabled: ignored
        cycle(1'b0, 1'b0, 1'b1, 32'h6, 4'hF);
        n_tests++;
        if (synced !== 1'b0 || word_cnt !== 9'd3 || err_cnt !== 9'd1 || exp_data !== 32'h1237) begin
            n_fail++; $display("FAIL dis_hold: sync=%b wc=%0d ec=%0d exp=%h want 0/3/1/00001237",
                               synced, word_cnt, err_cnt, exp_data);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'h7000, 4'hF);   // enable cycle: word ignored
        n_tests++;
        if (word_cnt !== 9'd3 || synced !== 1'b0) begin
            n_fail++; $display("FAIL en_first_ignored: wc=%0d sync=%b want 3/0", word_cnt, synced);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'h8000, 4'hF);
        n_tests++;
        if (exp_data !== 32'h8001 || word_cnt !== 9'd4 || err_flag !== 1'b1) begin
            n_fail++; $display("FAIL en_reseed: exp=%h wc=%0d flag=%b want 00008001/4/1",
                               exp_data, word_cnt, err_flag);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 1'b1, 32'h8000 + i, 4'hF);
        #2 fifoRstn = 1'b0;
        #1;
        n_tests++;
        if ({word_cnt, err_cnt, err_flag, synced, exp_data, ferr_data, ferr_exp} !== '0) begin
            n_fail++; $display("FAIL async_reset: wc=%0d ec=%0d flag=%b sync=%b exp=%h, zero required",
                               word_cnt, err_cnt, err_flag, synced, exp_data);
        end
        @(negedge fifoClk);
        #2 fifoRstn = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h500, 4'hF);
        n_tests++;
        if (exp_data !== 32'h501 || word_cnt !== 9'd1 || synced !== 1'b1 || err_flag !== 1'b0) begin
            n_fail++; $display("FAIL async_reseed: exp=%h wc=%0d sync=%b flag=%b want 00000501/1/1/0",
                               exp_data, word_cnt, synced, err_flag);
        end
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        for (int i = 0; i < 600; i++) cycle(1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        n_tests++;
        if (word_cnt !== CMAX || err_cnt !== CMAX) begin
            n_fail++; $display("FAIL saturation: wc=%0d ec=%0d want 511/511", word_cnt, err_cnt);
        end
        n_tests++;
        if (exp_data !== 32'd601 || ferr_exp !== 32'h1) begin
            n_fail++; $display("FAIL sat_exp: exp=%h fexp=%h want 00000259/00000001", exp_data, ferr_exp);
        end
    endtask

    task automatic test_random();
        logic          en, clr, vld;
        logic [DW-1:0] d;
        logic [3:0]    b;
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 24) != 0);
            clr = ($urandom_range(0, 79) == 0);
            vld = ($urandom_range(0, 3) != 0);
            b   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            d   = m_synced ? m_exp : $urandom;
            if ($urandom_range(0, 9) == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
            cycle(en, clr, vld, d, b);
            n_tests++;
            if (word_cnt !== m_words || err_cnt !== m_errs || err_flag !== m_flag || synced !== m_synced) begin
                n_fail++;
                $display("FAIL rnd_cnt[%0d]: wc=%0d ec=%0d flag=%b sync=%b want %0d/%0d/%b/%b",
                         i, word_cnt, err_cnt, err_flag, synced, m_words, m_errs, m_flag, m_synced);
            end
            n_tests++;
            if (exp_data !== m_exp || ferr_data !== m_fdata || ferr_exp !== m_fexp) begin
                n_fail++;
                $display("FAIL rnd_data[%0d]: exp=%h fd=%h fe=%h want %h/%h/%h",
                         i, exp_data, ferr_data, ferr_exp, m_exp, m_fdata, m_fexp);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_incrementing();
        test_wrap();
        test_first_error();
        test_byte_enable();
        test_clear_collision();
        test_disable_hold();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
